alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec.sv | 191 +++++++++++++++++++
 tb/tb_alu_exec.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// Registered ALU with a serial 1-bit-per-cycle shifter (IDLE/SHIFT FSM).
// Define ALU_EXEC_FAST_SHIFT_EN to use a single-cycle barrel shifter instead.
module alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] comb_res;
    logic             comb_ill;

    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic             done_q, done_d;

    assign shamt = SrcB[SHW-1:0];

    // Single-cycle result; in the serial build a shift only lands here with amount 0.
    always_comb begin
        comb_res = '0;
        comb_ill = 1'b0;
        case (ALUControl)
            OP_ADD:  comb_res = SrcA + SrcB;
            OP_SUB:  comb_res = SrcA - SrcB;
            OP_AND:  comb_res = SrcA & SrcB;
            OP_OR:   comb_res = SrcA | SrcB;
            OP_XOR:  comb_res = SrcA ^ SrcB;
            OP_SLT:  comb_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            OP_SLTU: comb_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
`ifdef ALU_EXEC_FAST_SHIFT_EN
            OP_SLL:  comb_res = SrcA << shamt;
            OP_SRL:  comb_res = SrcA >> shamt;
            OP_SRA:  comb_res = WIDTH'($signed(SrcA) >>> shamt);
`else
            OP_SLL, OP_SRL, OP_SRA: comb_res = SrcA;
`endif
            default: comb_ill = 1'b1;
        endcase
    end

`ifdef ALU_EXEC_FAST_SHIFT_EN

    assign busy = 1'b0;

    always_comb begin
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        done_d    = 1'b0;
        if (start) begin
            result_d  = comb_res;
            zero_d    = (comb_res == '0);
            illegal_d = comb_ill;
            done_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
        end
    end

`else

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] shift_step;
    logic             launch_shift;

    assign busy = (state_q == ST_SHIFT);
    assign launch_shift = ((ALUControl == OP_SLL) || (ALUControl == OP_SRL) ||
                           (ALUControl == OP_SRA)) && (shamt != '0);

    always_comb begin
        unique case (op_q)
            OP_SLL:  shift_step = {shreg_q[WIDTH-2:0], 1'b0};
            OP_SRA:  shift_step = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
            default: shift_step = {1'b0, shreg_q[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (launch_shift) begin
                        state_d = ST_SHIFT;
                        shreg_d = SrcA;
                        cnt_d   = shamt;
                        op_d    = ALUControl;
                    end else begin
                        result_d  = comb_res;
                        zero_d    = (comb_res == '0);
                        illegal_d = comb_ill;
                        done_d    = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                shreg_d = shift_step;
                cnt_d   = cnt_q - SHW'(1);
                // Last 1-bit step: publish the result and return to IDLE.
                if (cnt_q == SHW'(1)) begin
                    state_d   = ST_IDLE;
                    result_d  = shift_step;
                    zero_d    = (shift_step == '0);
                    illegal_d = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            op_q      <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
        end
    end

`endif

    assign done      = done_q;
    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec (WIDTH=32); serial-shift timing by default,
// single-cycle timing when ALU_EXEC_FAST_SHIFT_EN is defined.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        busy;
    logic        done;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen;

    alu_exec #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .busy       (busy),
        .done       (done),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start      = 1'b1;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        ALUControl = 4'b0000;
        SrcA = 32'd9;
        SrcB = 32'd9;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", ALUResult, 0);
        chk("rst_zero", Zero, 0);
        chk("rst_illegal", illegal, 0);

        // First cycle after reset, then back-to-back single-cycle ops.
        reset = 1'b0;
        drive(4'b0000, 32'd5, 32'd7);
        tick();
        chk("add_done", done, 1);
        chk("add_busy", busy, 0);
        chk("add_result", ALUResult, 32'd12);
        chk("add_zero", Zero, 0);
        drive(4'b0001, 32'd3, 32'd3);
        tick();
        chk("sub_done", done, 1);
        chk("sub_result", ALUResult, 0);
        chk("sub_zero", Zero, 1);
        drive(4'b0101, 32'hFFFF_FFFF, 32'd1);
        tick();
        chk("slt_done", done, 1);
        chk("slt_result", ALUResult, 1);
        chk("slt_zero", Zero, 0);
        drive(4'b0110, 32'hFFFF_FFFF, 32'd1);
        tick();
        chk("sltu_result", ALUResult, 0);
        chk("sltu_zero", Zero, 1);
        drive(4'b0010, 32'h0000_F0F0, 32'h0000_FF00);
        tick();
        chk("and_result", ALUResult, 32'h0000_F000);
        drive(4'b0011, 32'h0000_F0F0, 32'h0000_FF00);
        tick();
        chk("or_result", ALUResult, 32'h0000_FFF0);
        drive(4'b0100, 32'h0000_F0F0, 32'h0000_FF00);
        tick();
        chk("xor_result", ALUResult, 32'h0000_0FF0);
        drive(4'b0000, 32'hFFFF_FFFF, 32'd2);
        tick();
        chk("add_wrap", ALUResult, 32'd1);
        drive(4'b0001, 32'd0, 32'd1);
        tick();
        chk("sub_wrap", ALUResult, 32'hFFFF_FFFF);
        chk("sub_wrap_done", done, 1);
        start = 1'b0;
        tick();
        chk("idle_done", done, 0);
        chk("idle_hold", ALUResult, 32'hFFFF_FFFF);

        // Shift amount 0 via ignored upper SrcB bits: single-cycle even in serial build.
        drive(4'b0111, 32'h0000_1234, 32'h0000_0020);
        tick();
        start = 1'b0;
        chk("sll0_done", done, 1);
        chk("sll0_busy", busy, 0);
        chk("sll0_result", ALUResult, 32'h0000_1234);

        // sra by 4, operands changed after capture.
        drive(4'b1001, 32'h8000_0000, 32'h0000_0024);
        tick();
        start = 1'b0;
        SrcA = 32'h0000_0001;
        SrcB = 32'h0000_0000;
`ifdef ALU_EXEC_FAST_SHIFT_EN
        chk("sra_fast_done", done, 1);
        chk("sra_fast_busy", busy, 0);
        chk("sra_fast_result", ALUResult, 32'hF800_0000);
        tick();
        chk("sra_fast_done_low", done, 0);
`else
        chk("sra_t1_busy", busy, 1);
        chk("sra_t1_done", done, 0);
        chk("sra_t1_hold", ALUResult, 32'h0000_1234);
        tick();
        chk("sra_t2_busy", busy, 1);
        drive(4'b0000, 32'd1, 32'd1);
        tick();
        start = 1'b0;
        chk("sra_t3_busy", busy, 1);
        chk("sra_t3_done", done, 0);
        chk("sra_t3_hold", ALUResult, 32'h0000_1234);
        tick();
        chk("sra_t4_busy", busy, 1);
        chk("sra_t4_done", done, 0);
        tick();
        chk("sra_t5_busy", busy, 0);
        chk("sra_t5_done", done, 1);
        chk("sra_t5_result", ALUResult, 32'hF800_0000);
        chk("sra_t5_zero", Zero, 0);
        tick();
        chk("sra_t6_done", done, 0);
        chk("sra_t6_hold", ALUResult, 32'hF800_0000);
`endif

        // srl by 1: shortest serial shift.
        drive(4'b1000, 32'h8000_0000, 32'h0000_0021);
        tick();
        start = 1'b0;
`ifndef ALU_EXEC_FAST_SHIFT_EN
        chk("srl1_t1_busy", busy, 1);
        chk("srl1_t1_done", done, 0);
        tick();
`endif
        chk("srl1_done", done, 1);
        chk("srl1_busy", busy, 0);
        chk("srl1_result", ALUResult, 32'h4000_0000);

        // sll by 31, reset in T+10.
        drive(4'b0111, 32'd1, 32'd31);
        tick();
        start = 1'b0;
`ifdef ALU_EXEC_FAST_SHIFT_EN
        chk("sll31_fast_result", ALUResult, 32'h8000_0000);
        chk("sll31_fast_done", done, 1);
`else
        for (int i = 1; i < 10; i++) tick();
        chk("sll31_t10_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("sll31_rst_busy", busy, 0);
        chk("sll31_rst_done", done, 0);
        chk("sll31_rst_result", ALUResult, 0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) done_seen++;
        end
        chk("sll31_no_done", done_seen, 0);
`endif

        // Illegal code, then a legal op clears the flag.
        drive(4'b0000, 32'd2, 32'd2);
        tick();
        chk("pre_ill_result", ALUResult, 32'd4);
        drive(4'b1100, 32'd5, 32'd7);
        tick();
        chk("ill_done", done, 1);
        chk("ill_result", ALUResult, 0);
        chk("ill_zero", Zero, 1);
        chk("ill_flag", illegal, 1);
        drive(4'b0000, 32'd1, 32'd1);
        tick();
        start = 1'b0;
        chk("post_ill_flag", illegal, 0);
        chk("post_ill_result", ALUResult, 32'd2);
        chk("post_ill_zero", Zero, 0);
        tick();
        chk("post_ill_hold", illegal, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
